// File: rtl/uart_cmd_pkg.sv
// Shared types, ASCII constants and hex helpers for the UART LED command parser.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    P_IDLE,
    P_GET_HI,
    P_GET_LO,
    P_EXP_CR,
    P_FLUSH,
    P_RESP
  } parse_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_WAIT_HI,
    TX_WAIT_LO
  } tx_state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

  // Element [0] is the first byte on the wire.
  typedef logic [3:0][7:0] reply_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_L  = 8'h4C;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_E  = 8'h45;

  localparam reply_t REPLY_OK = {ASCII_LF, ASCII_CR, ASCII_K, ASCII_O};
  localparam reply_t REPLY_ER = {ASCII_LF, ASCII_CR, ASCII_R, ASCII_E};

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) ||
           (b >= 8'h41 && b <= 8'h46) ||
           (b >= 8'h61 && b <= 8'h66);
  endfunction

  // Letters A-F and a-f share low nibbles 1-6, so adding 9 covers both cases.
  function automatic logic [3:0] hex2nib(input logic [7:0] b);
    if (b <= 8'h39) return b[3:0];
    return b[3:0] + 4'd9;
  endfunction

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_led_cmd_tx_seq.sv
// Sends a 4-byte reply through the transmitter's enable/busy handshake.
module uart_tx_sequencer
  import uart_cmd_pkg::*;
#(
  parameter int BUSY_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  reply_t     buf_i,
  input  logic       tx_busy_i,
  output logic       tx_en_o,
  output logic [7:0] tx_data_o,
  output logic       done_o
);

  localparam int CNT_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_WAIT - 1);

  tx_state_e        state_q;
  reply_t           buf_q;
  logic [1:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tx_en_q;
  logic [7:0]       tx_data_q;
  logic             done_q;

  // NOTE: the reply buffer is always loaded before it is read, so it carries
  // no reset and lives in its own reset-free block.
  always_ff @(posedge clk) begin
    if (start_i && state_q == TX_IDLE) buf_q <= buf_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TX_IDLE;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // block tied to the same clock edge regardless of statement order.
      tx_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          if (start_i) begin
            idx_q <= 2'd0;
            if (!tx_busy_i) begin
              tx_en_q   <= 1'b1;
              tx_data_q <= buf_i[0];
              cnt_q     <= '0;
              state_q   <= TX_WAIT_HI;
            end else begin
              state_q <= TX_SEND;
            end
          end
        end
        TX_SEND: begin
          if (!tx_busy_i) begin
            tx_en_q   <= 1'b1;
            tx_data_q <= buf_q[idx_q];
            cnt_q     <= '0;
            state_q   <= TX_WAIT_HI;
          end
        end
        TX_WAIT_HI: begin
          if (tx_busy_i || cnt_q == CNT_LAST) state_q <= TX_WAIT_LO;
          else                                cnt_q   <= cnt_q + 1'b1;
        end
        TX_WAIT_LO: begin
          if (!tx_busy_i) begin
            if (idx_q == 2'd3) begin
              done_q  <= 1'b1;
              state_q <= TX_IDLE;
            end else begin
              idx_q   <= idx_q + 2'd1;
              state_q <= TX_SEND;
            end
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_en_o   = tx_en_q;
  assign tx_data_o = tx_data_q;
  assign done_o    = done_q;

endmodule

// File: rtl/uart_led_cmd.sv
// ASCII line parser: "Lhh\r" sets the LEDs, "R\r" reads them back; replies via the TX sequencer.
module uart_led_cmd
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] LED_RESET_VAL = 8'h00,
  parameter int         BUSY_WAIT     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_parity_err_i,
  output logic       tx_en_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_busy_i,
  output logic [7:0] leds_o,
  output logic       cmd_done_o,
  output logic       overrun_o
);

  parse_state_e state_q;
  op_e          op_q;
  logic [3:0]   hi_q, lo_q;
  logic [7:0]   leds_q;
  logic         overrun_q;

  logic   accept, byte_ok, is_cr, is_lf, is_l, is_r, is_hx;
  logic   start;
  reply_t reply;
  logic   seq_done;

  // A parity-errored byte is accepted but matches no token, so it lands in FLUSH.
  assign accept  = rx_valid_i && (state_q != P_RESP);
  assign byte_ok = accept && !rx_parity_err_i;
  assign is_cr   = byte_ok && (rx_data_i == ASCII_CR);
  assign is_lf   = byte_ok && (rx_data_i == ASCII_LF);
  assign is_l    = byte_ok && ((rx_data_i | 8'h20) == (ASCII_L | 8'h20));
  assign is_r    = byte_ok && ((rx_data_i | 8'h20) == (ASCII_R | 8'h20));
  assign is_hx   = byte_ok && is_hex(rx_data_i);

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    start = 1'b0;
    reply = REPLY_ER;
    case (state_q)
      P_GET_HI, P_GET_LO, P_FLUSH: start = is_cr;
      P_EXP_CR: begin
        start = is_cr;
        if (op_q == OP_WRITE) reply = REPLY_OK;
        else reply = {ASCII_LF, ASCII_CR, nib2hex(leds_q[3:0]), nib2hex(leds_q[7:4])};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= P_IDLE;
      op_q      <= OP_READ;
      hi_q      <= 4'h0;
      lo_q      <= 4'h0;
      leds_q    <= LED_RESET_VAL;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        P_IDLE: begin
          if (accept) begin
            if (is_l) state_q <= P_GET_HI;
            else if (is_r) begin
              op_q    <= OP_READ;
              state_q <= P_EXP_CR;
            end else if (!(is_cr || is_lf)) state_q <= P_FLUSH;
          end
        end
        P_GET_HI: begin
          if (accept) begin
            if (is_hx) begin
              hi_q    <= hex2nib(rx_data_i);
              state_q <= P_GET_LO;
            end else if (is_cr) state_q <= P_RESP;
            else                state_q <= P_FLUSH;
          end
        end
        P_GET_LO: begin
          if (accept) begin
            if (is_hx) begin
              lo_q    <= hex2nib(rx_data_i);
              op_q    <= OP_WRITE;
              state_q <= P_EXP_CR;
            end else if (is_cr) state_q <= P_RESP;
            else                state_q <= P_FLUSH;
          end
        end
        P_EXP_CR: begin
          if (accept) begin
            if (is_cr) begin
              if (op_q == OP_WRITE) leds_q <= {hi_q, lo_q};
              state_q <= P_RESP;
            end else state_q <= P_FLUSH;
          end
        end
        P_FLUSH: if (is_cr) state_q <= P_RESP;
        P_RESP: begin
          if (rx_valid_i) overrun_q <= 1'b1;
          if (seq_done)   state_q   <= P_IDLE;
        end
        default: state_q <= P_IDLE;
      endcase
    end
  end

  uart_tx_sequencer #(.BUSY_WAIT(BUSY_WAIT)) u_tx_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .buf_i     (reply),
    .tx_busy_i (tx_busy_i),
    .tx_en_o   (tx_en_o),
    .tx_data_o (tx_data_o),
    .done_o    (seq_done)
  );

  assign leds_o     = leds_q;
  assign cmd_done_o = seq_done;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_uart_led_cmd.sv
// Directed bench for uart_led_cmd with a model transmitter that holds busy for 20 cycles per byte.
module tb_uart_led_cmd;

  localparam int BW = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_perr = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_en_o, cmd_done_o, overrun_o;
  logic [7:0] tx_data_o, leds_o;

  uart_led_cmd #(.LED_RESET_VAL(8'h00), .BUSY_WAIT(BW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_valid_i      (rx_valid),
    .rx_data_i       (rx_data),
    .rx_parity_err_i (rx_perr),
    .tx_en_o         (tx_en_o),
    .tx_data_o       (tx_data_o),
    .tx_busy_i       (tx_busy),
    .leds_o          (leds_o),
    .cmd_done_o      (cmd_done_o),
    .overrun_o       (overrun_o)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model transmitter: busy for 20 cycles after each load unless tied low.
  bit tie_low = 1'b0;
  int busy_left = 0;
  always @(posedge clk) begin
    if (tie_low) begin
      tx_busy   <= 1'b0;
      busy_left <= 0;
    end else if (tx_en_o) begin
      tx_busy   <= 1'b1;
      busy_left <= 20;
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else begin
      tx_busy   <= 1'b0;
      busy_left <= 0;
    end
  end

  // Monitor sampled on the falling edge.
  logic [7:0] tx_q[$];
  int         pulse_t[$];
  int         cyc = 0;
  int         done_cnt = 0;
  int         viol = 0;
  bit         prev_en = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (tx_en_o) begin
      tx_q.push_back(tx_data_o);
      pulse_t.push_back(cyc);
      if (prev_en) viol++;
      if (tx_busy) viol++;
    end
    prev_en = tx_en_o;
    if (cmd_done_o) done_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input logic perr = 1'b0);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    rx_perr  = perr;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_perr  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target);
    for (int i = 0; i < 800 && done_cnt < target; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    check({tag, "_done_cnt"}, done_cnt, target);
  endtask

  task automatic check_reply(input string tag, input logic [31:0] exp);
    logic [7:0] got;
    check({tag, "_len"}, tx_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'h00;
      check($sformatf("%s_b%0d", tag, i), {24'h0, got}, {24'h0, exp[31-8*i -: 8]});
    end
    tx_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_leds", leds_o, 8'h00);
    check("rst_tx_en", tx_en_o, 1'b0);
    check("rst_tx_data", tx_data_o, 8'h00);
    check("rst_done", cmd_done_o, 1'b0);
    check("rst_overrun", overrun_o, 1'b0);

    // Write A5
    send_byte(8'h4C); send_byte(8'h41); send_byte(8'h35);
    check("t1_leds_pre", leds_o, 8'h00);
    send_byte(8'h0D);
    check("t1_leds_post", leds_o, 8'hA5);
    wait_done("t1", 1);
    check_reply("t1_ok", 32'h4F4B0D0A);

    // Stray LF in IDLE, then lowercase read
    send_byte(8'h0A); send_byte(8'h72); send_byte(8'h0D);
    wait_done("t2", 2);
    check_reply("t2_read", 32'h41350D0A);
    check("t2_leds", leds_o, 8'hA5);

    // Bad hex digit, then CR straight after L
    send_byte(8'h4C); send_byte(8'h47); send_byte(8'h31); send_byte(8'h0D);
    wait_done("t3a", 3);
    check_reply("t3a_er", 32'h45520D0A);
    send_byte(8'h4C); send_byte(8'h0D);
    wait_done("t3b", 4);
    check_reply("t3b_er", 32'h45520D0A);
    check("t3_leds", leds_o, 8'hA5);

    // Parity error on the terminating CR
    send_byte(8'h4C); send_byte(8'h31); send_byte(8'h32); send_byte(8'h0D, 1'b1);
    repeat (10) @(negedge clk);
    check("t4_no_reply_on_perr", tx_q.size(), 0);
    send_byte(8'h0D);
    wait_done("t4", 5);
    check_reply("t4_er", 32'h45520D0A);
    check("t4_leds", leds_o, 8'hA5);

    // Byte arriving mid-reply is dropped and flagged
    check("t5_overrun_pre", overrun_o, 1'b0);
    send_byte(8'h52); send_byte(8'h0D);
    for (int i = 0; i < 50 && !tx_busy; i++) @(negedge clk);
    check("t5_busy_seen", tx_busy, 1'b1);
    send_byte(8'h52);
    check("t5_overrun_set", overrun_o, 1'b1);
    wait_done("t5", 6);
    check_reply("t5_read", 32'h41350D0A);
    check("t5_overrun_sticky", overrun_o, 1'b1);

    // Reset after the second byte of a reply
    send_byte(8'h4C); send_byte(8'h33); send_byte(8'h63); send_byte(8'h0D);
    check("t6_leds_3c", leds_o, 8'h3C);
    for (int i = 0; i < 400 && tx_q.size() < 2; i++) @(negedge clk);
    check("t6_second_pulse", tx_q.size() >= 2, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_leds", leds_o, 8'h00);
    check("t6_rst_tx_en", tx_en_o, 1'b0);
    check("t6_rst_tx_data", tx_data_o, 8'h00);
    check("t6_rst_done", cmd_done_o, 1'b0);
    check("t6_rst_overrun", overrun_o, 1'b0);
    @(negedge clk);
    rst_n   = 1'b1;
    tie_low = 1'b1;
    tx_q.delete();
    repeat (100) @(negedge clk);
    check("t6_silent_after_rst", tx_q.size(), 0);
    check("t6_done_after_rst", done_cnt, 6);

    // Busy tied low: four pulses paced by the busy timeout
    pulse_t.delete();
    send_byte(8'h52); send_byte(8'h0D);
    wait_done("t7", 7);
    check("t7_pulses", pulse_t.size(), 4);
    check_reply("t7_read", 32'h30300D0A);
    for (int i = 1; i < 4 && i < pulse_t.size(); i++) begin
      check($sformatf("t7_gap%0d_in_range", i),
            (pulse_t[i] - pulse_t[i-1] >= BW + 1) && (pulse_t[i] - pulse_t[i-1] <= BW + 3), 1'b1);
    end

    check("tx_en_protocol_violations", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/uart_led_cmd.md
Name: uart_led_cmd

Overview:
- Command-parser stage that sits between the UART receiver and the UART transmitter in the top-level design.
- Consumes received bytes through their valid/data/parity-error outputs and parses a small ASCII line protocol.
- Drives the 8 board LEDs and queues a fixed 4-byte reply for the UART transmitter through its enable/data/busy handshake.
- Replaces the current raw RX-to-TX loopback.

Parameters:
- LED_RESET_VAL, 8'h00, value loaded into leds_o on reset.
- BUSY_WAIT, 2, maximum cycles to wait for tx_busy_i to rise after a tx_en_o pulse before treating the byte as sent.

Ports:
- clk  input  1  system clock (25 MHz board clock).
- rst_n  input  1  reset, asynchronous assert, active-low.
- rx_valid_i  input  1  one-cycle strobe, received byte present.
- rx_data_i  input  8  received byte; sampled only when rx_valid_i=1.
- rx_parity_err_i  input  1  parity error for the byte qualified by rx_valid_i.
- tx_en_o  output  1  one-cycle strobe, transmitter loads tx_data_o.
- tx_data_o  output  8  byte to transmit; held stable until the next pulse.
- tx_busy_i  input  1  transmitter busy.
- leds_o  output  8  LED register.
- cmd_done_o  output  1  one-cycle pulse when a reply finishes sending.
- overrun_o  output  1  sticky flag: an RX byte was dropped during a reply; cleared only by reset.

Behaviour:
- Protocol:
  - "L" hh CR: set LEDs to hex hh. Reply "OK\r\n" = 4F 4B 0D 0A.
  - "R" CR: reply with leds_o as two uppercase hex chars, then 0D 0A.
  - Any malformed line: reply "ER\r\n" = 45 52 0D 0A.
  - 'L'/'l' and 'R'/'r' are both accepted.
  - Hex digits 0-9, A-F and a-f are all accepted.
- Reset values: leds_o=LED_RESET_VAL, tx_en_o=0, tx_data_o=0, cmd_done_o=0, overrun_o=0, state=IDLE.
- Reset mid-reply aborts immediately; no further tx_en_o is issued.
- A byte is accepted only on a cycle with rx_valid_i=1 and state != RESP.
- A byte with rx_parity_err_i=1 counts as an invalid byte in every parse state, including CR.
- Parse FSM (transitions occur on accepted bytes only):
  - IDLE:
    - L -> GET_HI
    - R -> EXP_CR with op=READ
    - CR or LF (0A) -> stay in IDLE (tolerates CRLF line endings)
    - anything else -> FLUSH
  - GET_HI:
    - hex -> store high nibble, go to GET_LO
    - CR -> RESP with ER
    - anything else -> FLUSH
  - GET_LO:
    - hex -> store low nibble, go to EXP_CR with op=WRITE
    - CR -> RESP with ER
    - anything else -> FLUSH
  - EXP_CR:
    - CR -> execute the command
    - anything else -> FLUSH
  - FLUSH:
    - valid CR -> RESP with ER
    - all other bytes are discarded
- Execute on the CR accepted at cycle N:
  - WRITE: leds_o takes {hi,lo} at N+1; reply OK.
  - READ: reply bytes are built from leds_o as it stands at cycle N.
- Reply buffer is 4 bytes, loaded at N; RESP is entered at N+1.
- RESP transmit sub-sequence:
  - SEND: when tx_busy_i=0, pulse tx_en_o for one cycle with the current byte. Earliest first pulse is N+1.
  - WAIT_HI: wait for tx_busy_i=1, or for BUSY_WAIT cycles to elapse.
  - WAIT_LO: wait for tx_busy_i=0.
  - After byte 3 completes: pulse cmd_done_o for one cycle and return to IDLE.
  - tx_en_o is never asserted on two consecutive cycles.
  - tx_en_o is never asserted while tx_busy_i=1.
- rx_valid_i=1 during RESP: the byte is dropped and overrun_o is set.
- An rx_valid_i arriving in the same cycle the FSM returns to IDLE is dropped (the state is still RESP in that cycle).
- Hex conversion: a nibble of 10-15 maps to 'A'-'F' (8'h41-8'h46).

Decomposition:
- Package uart_cmd_pkg holds:
  - parse-state enum and tx sub-state enum;
  - ASCII constants (CR, LF, 'L', 'R', 'O', 'K', 'E');
  - functions is_hex, hex2nib, nib2hex;
  - the four reply byte constants.
- One sub-module, uart_tx_sequencer:
  - inputs: 4-byte buffer, start pulse;
  - runs SEND / WAIT_HI / WAIT_LO against tx_busy_i;
  - outputs: tx_en_o, tx_data_o, done pulse.
- The parser FSM stays in uart_led_cmd.

Test Plan:
- Bytes 4C 41 35 0D, with a model transmitter asserting busy for 20 cycles per byte -> leds_o=8'hA5 one cycle after the CR; tx bytes 4F 4B 0D 0A; cmd_done_o pulses once.
- After the previous test, send 72 0D -> tx bytes 41 35 0D 0A; leds_o unchanged.
- Send 4C 47 31 0D -> tx 45 52 0D 0A, leds_o unchanged. Then send 4C 0D -> ER again.
- Send 4C 31 32 with parity error asserted on the CR byte, then a clean 0D -> parity error sends the FSM to FLUSH; the clean CR produces ER; leds_o unchanged.
- Inject rx_valid_i with 0x52 while the first reply byte is busy -> byte dropped, overrun_o=1 stays set, reply completes intact.
- Assert rst_n=0 after the second tx_en_o of a reply -> all outputs return to reset values asynchronously; no tx_en_o until a new command is received. Also tie tx_busy_i=0 -> 4 pulses spaced by BUSY_WAIT timeouts, with tx_en_o never on consecutive cycles.
